bcd2bin: RTL and testbench
==========================

BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 Parameter SHIFT_MAX, default 5'd20, SHALL set the number of shift/correct steps and the binary result width.
REQ-002 sys_clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 unit, ten, hun, tho, ten_tho, hun_hun  input  4 each  BCD digits, least significant to most significant.
REQ-006 sign  input  1  sign flag; passed through unchanged to sign_out.
REQ-007 data  output  20  binary result, registered.
REQ-008 sign_out  output  1  sign latched at start; updates in the same cycle as data.
REQ-009 busy  output  1  high from start acceptance until done.
REQ-010 done  output  1  one-cycle pulse when data and sign_out update.
REQ-011 err  output  1  one-cycle pulse, coincident with done, when any input digit is greater than 9.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 On the rising edge N where state is IDLE and start=1, the block SHALL:
- latch the six digits into a 24-bit BCD register, hun_hun in bits [23:20];
- latch sign;
- clear the 20-bit binary accumulator and the step counter;
- set busy=1 and enter SHIFT.
REQ-014 If any latched digit is greater than 9, the edge after acceptance SHALL go to DONE without shifting.
- The DONE edge then SHALL pulse done=1 and err=1.
- data SHALL be forced to 0; sign_out SHALL take the latched sign.
REQ-015 In SHIFT, each cycle SHALL perform one step:
- shift {BCD register, accumulator} right by one; the BCD LSB enters the accumulator MSB;
- then subtract 3 from every BCD nibble that is 8 or greater;
- increment the counter.
REQ-016 After the step with counter = SHIFT_MAX-1 (edge N+20 for valid input), the state SHALL be DONE.
REQ-017 On the DONE edge (N+21), the block SHALL:
- load data from the accumulator and sign_out from the latched sign;
- pulse done=1 for exactly one cycle;
- clear busy and return to IDLE.
- Latency from the start edge to done high is 21 cycles.
REQ-018 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-019 Back-to-back operation: a start sampled in the cycle done is high (state IDLE) SHALL be accepted.
REQ-020 Between conversions, data and sign_out SHALL hold their last values.
REQ-021 Input digits SHALL not need to stay stable after the acceptance edge.
REQ-022 The maximum valid input 999999 (0xF423F) SHALL fit in 20 bits; no overflow indication is required.

Reset
REQ-023 When sys_rst_n=0, the block SHALL asynchronously:
- set state to IDLE;
- clear data, sign_out, busy, done, err, the counter, the BCD register and the accumulator.
REQ-024 Reset asserted mid-conversion SHALL abort it with no done pulse; after release the block SHALL accept a new start.

Structure
REQ-025 A shared package SHALL hold:
- the state encoding;
- the nibble width (4);
- the default SHIFT_MAX (20);
- the BCD register width (24).
REQ-026 Sub-module bcd_nibble_adj SHALL implement the combinational per-nibble rule "if nibble is 8 or greater, subtract 3"; bcd2bin SHALL instantiate it six times.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Digits 9,9,9,9,9,9 with sign=1, start pulsed -> done exactly 21 cycles later; data=20'd999999, sign_out=1, err=0.
- Digits hun_hun..unit = 1,2,3,4,5,6 with sign=0 -> data=20'd123456, sign_out=0; then immediate restart with all digits 0 -> data=0 after 21 cycles.
- ten=4'hA, other digits 0 -> done and err pulse together on the 2nd edge after acceptance; data=0; busy low afterwards.
- start re-pulsed at cycles 5 and 20 of a 987654 conversion -> single done; data=987654; no second conversion starts.
- sys_rst_n pulsed low at cycle 10 of a 981106 conversion -> all outputs 0 immediately, no done; a new 000042 conversion -> data=42.
- Random valid 6-digit values compared against a decimal reference model -> data matches in all cases.

Source files
------------

// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the BCD-to-binary converter: state encoding,
// field widths and a digit validity helper.
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int          NIB_W         = 4;
  localparam int          NUM_DIG       = 6;
  localparam int          BCD_W         = 24;
  localparam logic [4:0]  SHIFT_MAX_DEF = 5'd20;

  // True when any packed nibble holds a non-decimal code (A..F).
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (v[i*NIB_W +: NIB_W] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// Request/result bundle between a conversion requester (master)
// and the bcd2bin converter (slave).
interface bcd2bin_if #(
  parameter int DATA_W = 20
);
  logic              start;
  logic [3:0]        unit;
  logic [3:0]        ten;
  logic [3:0]        hun;
  logic [3:0]        tho;
  logic [3:0]        ten_tho;
  logic [3:0]        hun_hun;
  logic              sign;
  logic [DATA_W-1:0] data;
  logic              sign_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, unit, ten, hun, tho, ten_tho, hun_hun, sign,
    input  data, sign_out, busy, done, err
  );

  modport slave (
    input  start, unit, ten, hun, tho, ten_tho, hun_hun, sign,
    output data, sign_out, busy, done, err
  );
endinterface

// File: rtl/bcd_nibble_adj.sv
// Per-digit correction for reverse double-dabble: a nibble of 8 or more
// after the right shift is reduced by 3.
module bcd_nibble_adj
  import bcd2bin_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [NIB_W-1:0] nib_o
);

  assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;

endmodule

// File: rtl/bcd2bin.sv
// Six-digit BCD to binary converter using serial reverse double-dabble:
// one right shift plus nibble correction per cycle, SHIFT_MAX steps.
module bcd2bin
  import bcd2bin_pkg::*;
#(
  parameter logic [4:0] SHIFT_MAX = SHIFT_MAX_DEF
) (
  input logic      sys_clk,
  input logic      sys_rst_n,
  bcd2bin_if.slave bus
);

  state_e                 state_q, state_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [SHIFT_MAX-1:0]   acc_q, acc_d;
  logic [SHIFT_MAX-1:0]   data_q, data_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   sign_lat_q, sign_lat_d;
  logic                   bad_q, bad_d;
  logic                   sign_out_q, sign_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [BCD_W-1:0]       digits_in;
  logic [BCD_W-1:0]       bcd_shr;
  logic [BCD_W-1:0]       bcd_adj;

  assign digits_in = {bus.hun_hun, bus.ten_tho, bus.tho, bus.hun, bus.ten, bus.unit};
  assign bcd_shr   = {1'b0, bcd_q[BCD_W-1:1]};

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .nib_i (bcd_shr[g*NIB_W +: NIB_W]),
      .nib_o (bcd_adj[g*NIB_W +: NIB_W])
    );
  end

  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    acc_d      = acc_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    sign_lat_d = sign_lat_q;
    bad_d      = bad_q;
    sign_out_d = sign_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          bcd_d      = digits_in;
          sign_lat_d = bus.sign;
          bad_d      = has_bad_digit(digits_in);
          acc_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Invalid input skips the shift phase entirely; result is forced to 0.
        if (bad_q) begin
          state_d = ST_DONE;
        end else begin
          bcd_d = bcd_adj;
          acc_d = {bcd_q[0], acc_q[SHIFT_MAX-1:1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == SHIFT_MAX - 5'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        data_d     = bad_q ? '0 : acc_q;
        sign_out_d = sign_lat_q;
        done_d     = 1'b1;
        err_d      = bad_q;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      bcd_q      <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      sign_lat_q <= 1'b0;
      bad_q      <= 1'b0;
      sign_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      sign_lat_q <= sign_lat_d;
      bad_q      <= bad_d;
      sign_out_q <= sign_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.data     = data_q;
  assign bus.sign_out = sign_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Bench for bcd2bin: decimal reference model checked every cycle, plus
// directed scenarios with literal expectations and randomized conversions.
module tb_bcd2bin;

  logic clk;
  logic rst_n;
  bit   check_en;
  int   n_cmp;
  int   n_bad;

  bcd2bin_if bus ();

  bcd2bin u_dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int dec_value(input logic [3:0] hh, tt, th, h, t, u);
    return int'(hh) * 100000 + int'(tt) * 10000 + int'(th) * 1000 + int'(h) * 100 + int'(t) * 10 + int'(u);
  endfunction

  function automatic bit any_invalid(input logic [3:0] hh, tt, th, h, t, u);
    return (hh > 9) || (tt > 9) || (th > 9) || (h > 9) || (t > 9) || (u > 9);
  endfunction

  // Reference model: a request accepted while idle produces its decimal
  // value 21 edges later (2 edges for a bad digit); busy spans the wait.
  bit        exp_busy, exp_done, exp_err, exp_sign;
  int        exp_data;
  int        remain;
  int        pend_val;
  bit        pend_bad, pend_sign;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_err  <= 1'b0;
      exp_sign <= 1'b0;
      exp_data <= 0;
      remain   <= 0;
      pend_val <= 0;
      pend_bad <= 1'b0;
      pend_sign <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      exp_err  <= 1'b0;
      if (!exp_busy) begin
        if (bus.start) begin
          exp_busy  <= 1'b1;
          pend_bad  <= any_invalid(bus.hun_hun, bus.ten_tho, bus.tho, bus.hun, bus.ten, bus.unit);
          pend_val  <= dec_value(bus.hun_hun, bus.ten_tho, bus.tho, bus.hun, bus.ten, bus.unit);
          pend_sign <= bus.sign;
          remain    <= any_invalid(bus.hun_hun, bus.ten_tho, bus.tho, bus.hun, bus.ten, bus.unit) ? 2 : 21;
        end
      end else begin
        if (remain == 1) begin
          exp_done <= 1'b1;
          exp_err  <= pend_bad;
          exp_data <= pend_bad ? 0 : pend_val;
          exp_sign <= pend_sign;
          exp_busy <= 1'b0;
        end
        remain <= remain - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_done", 32'(bus.done), 32'(exp_done));
      chk("cyc_err", 32'(bus.err), 32'(exp_err));
      chk("cyc_busy", 32'(bus.busy), 32'(exp_busy));
      chk("cyc_data", 32'(bus.data), 32'(exp_data));
      chk("cyc_sign_out", 32'(bus.sign_out), 32'(exp_sign));
    end
  end

  task automatic set_digits(input logic [3:0] hh, tt, th, h, t, u, input logic s);
    bus.hun_hun = hh;
    bus.ten_tho = tt;
    bus.tho     = th;
    bus.hun     = h;
    bus.ten     = t;
    bus.unit    = u;
    bus.sign    = s;
  endtask

  // Raise start so the next rising edge accepts it; returns 2ns after that edge.
  task automatic pulse_start();
    @(posedge clk); #2;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic pulse_now();
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  // Counts edges after acceptance until done is seen; 0 edges means timeout.
  task automatic wait_done(input string name, output int edges);
    edges = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        edges = c;
        break;
      end
    end
    if (edges == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int first;
    logic [3:0] d [6];
    logic s;
    int v;
    bit bad;

    n_cmp    = 0;
    n_bad    = 0;
    check_en = 1'b0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check_en = 1'b1;
    rst_n    = 1'b1;
    #1;
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_sign_out", 32'(bus.sign_out), 32'd0);

    // All nines, negative
    set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1);
    pulse_start();
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    wait_done("s1", lat);
    chk("s1_latency", 32'(lat), 32'd21);
    chk("s1_data", 32'(bus.data), 32'd999999);
    chk("s1_sign_out", 32'(bus.sign_out), 32'd1);
    chk("s1_err", 32'(bus.err), 32'd0);

    // 123456 then back-to-back restart with zeros
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1'b0);
    pulse_start();
    wait_done("s2a", lat);
    chk("s2a_latency", 32'(lat), 32'd21);
    chk("s2a_data", 32'(bus.data), 32'd123456);
    chk("s2a_sign_out", 32'(bus.sign_out), 32'd0);
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    pulse_now();
    chk("s2b_busy", 32'(bus.busy), 32'd1);
    wait_done("s2b", lat);
    chk("s2b_latency", 32'(lat), 32'd21);
    chk("s2b_data", 32'(bus.data), 32'd0);

    // Non-decimal digit in the tens position
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'hA, 4'd0, 1'b0);
    pulse_start();
    wait_done("s3", lat);
    chk("s3_latency", 32'(lat), 32'd2);
    chk("s3_err", 32'(bus.err), 32'd1);
    chk("s3_data", 32'(bus.data), 32'd0);
    @(posedge clk); #1;
    chk("s3_busy_after", 32'(bus.busy), 32'd0);
    chk("s3_err_after", 32'(bus.err), 32'd0);

    // start re-pulsed mid-conversion must be ignored
    set_digits(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 1'b1);
    pulse_start();
    seen  = 0;
    first = 0;
    for (int c = 1; c <= 45; c++) begin
      bus.start = (c == 5 || c == 20);
      @(posedge clk); #1;
      if (bus.done) begin
        seen++;
        if (first == 0) first = c;
      end
    end
    bus.start = 1'b0;
    chk("s4_done_count", 32'(seen), 32'd1);
    chk("s4_latency", 32'(first), 32'd21);
    chk("s4_data", 32'(bus.data), 32'd987654);
    chk("s4_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of a conversion
    set_digits(4'd9, 4'd8, 4'd1, 4'd1, 4'd0, 4'd6, 1'b1);
    pulse_start();
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_data", 32'(bus.data), 32'd0);
    chk("s5_rst_sign_out", 32'(bus.sign_out), 32'd0);
    chk("s5_rst_busy", 32'(bus.busy), 32'd0);
    chk("s5_rst_done", 32'(bus.done), 32'd0);
    chk("s5_rst_err", 32'(bus.err), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    chk("s5_no_done", 32'(seen), 32'd0);
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 1'b0);
    pulse_start();
    wait_done("s5b", lat);
    chk("s5b_latency", 32'(lat), 32'd21);
    chk("s5b_data", 32'(bus.data), 32'd42);

    // Randomized conversions, occasionally with a non-decimal digit
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < 6; j++) begin
        if ($urandom_range(0, 19) == 0) d[j] = 4'($urandom_range(10, 15));
        else                            d[j] = 4'($urandom_range(0, 9));
      end
      s   = 1'($urandom_range(0, 1));
      v   = dec_value(d[5], d[4], d[3], d[2], d[1], d[0]);
      bad = any_invalid(d[5], d[4], d[3], d[2], d[1], d[0]);
      set_digits(d[5], d[4], d[3], d[2], d[1], d[0], s);
      pulse_start();
      set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
      wait_done("rnd", lat);
      chk("rnd_latency", 32'(lat), bad ? 32'd2 : 32'd21);
      chk("rnd_data", 32'(bus.data), bad ? 32'd0 : 32'(v));
      chk("rnd_sign_out", 32'(bus.sign_out), 32'(s));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
